// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, done/framing strobes.
// Optional 8E1 parity checking when UART_RX_PARITY_EN is defined.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_IDLE | wait for the line to return high (after reset or a break)
// IDLE      | line idle, watching for a start edge
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sample 8 data bits mid-bit, LSB first
// PARITY    | sample the even-parity bit (parity build only)
// STOP      | sample the stop bit, issue rxdone_o or frame_err_o
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] dataout_o,
    output logic       rxdone_o,
    output logic       frame_err_o,
    output logic       parity_err_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t FULL_LAST = cnt_t'(CLKS_PER_BIT - 1);
    localparam cnt_t HALF_LAST = cnt_t'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state;
    cnt_t       cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic       rx_meta;
    logic       rx_s;
    logic       baud_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // The start bit is confirmed at its middle; every later sample is one full bit on.
    assign baud_tick = (state == START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            par_bit      <= 1'b0;
            dataout_o    <= '0;
            rxdone_o     <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            rxdone_o     <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            if (baud_tick || state == IDLE || state == WAIT_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + cnt_t'(1);

            case (state)
                WAIT_IDLE: if (rx_s) state <= IDLE;
                IDLE:      if (!rx_s) state <= START;
                START: begin
                    if (baud_tick) begin
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= PARITY;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        par_bit <= rx_s;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (rx_s) begin
                            dataout_o    <= shift_reg;
                            rxdone_o     <= 1'b1;
                            parity_err_o <= par_bit ^ (^shift_reg);
                            state        <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
`else
    assign parity_err_o = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            dataout_o   <= '0;
            rxdone_o    <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rxdone_o    <= 1'b0;
            frame_err_o <= 1'b0;
            if (baud_tick || state == IDLE || state == WAIT_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + cnt_t'(1);

            case (state)
                WAIT_IDLE: if (rx_s) state <= IDLE;
                IDLE:      if (!rx_s) state <= START;
                START: begin
                    if (baud_tick) begin
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                    if (baud_tick) begin
                        if (rx_s) begin
                            dataout_o <= shift_reg;
                            rxdone_o  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
`endif

endmodule
